// File: rtl/ram_port_arbiter_if.sv
// Requester-side bus of the RAM port arbiter: two requesters packed side by side
// (requester 0 in the low half of addr/wdata, requester 1 in the high half).
interface ram_port_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
);
  logic [1:0]              req;
  logic [1:0]              lock;
  logic [1:0]              we;
  logic [2*ADDR_WIDTH-1:0] addr;
  logic [2*DATA_WIDTH-1:0] wdata;
  logic [1:0]              gnt;
  logic [1:0]              rvalid;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (
    output req, lock, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, lock, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one synchronous RAM port between two requesters,
// with bounded burst locking and a read-tag pipeline that steers rvalid.
module ram_port_arbiter #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1,
  parameter int MAX_BURST    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  ram_port_arbiter_if.slave     bus,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, OWN} state_e;

  state_e                  state_q, state_d;
  logic                    owner_q, owner_d;
  logic                    last_q, last_d;
  logic [CW-1:0]           burst_cnt_q, burst_cnt_d;
  logic [READ_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [READ_LATENCY-1:0] tag_id_q, tag_id_d;

  logic grant_vld;
  logic grant_id;
  logic extend;

  // Arbitration decision, shared by the next-state and output processes.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    extend    = 1'b0;
    if (state_q == OWN && bus.req[owner_q]) begin
      grant_vld = 1'b1;
      if (burst_cnt_q < CW'(MAX_BURST)) begin
        grant_id = owner_q;
        extend   = 1'b1;
      end else if (bus.req[~owner_q]) begin
        grant_id = ~owner_q;
      end else begin
        grant_id = owner_q;
      end
    end else if (&bus.req) begin
      grant_vld = 1'b1;
      grant_id  = ~last_q;
    end else if (|bus.req) begin
      grant_vld = 1'b1;
      grant_id  = bus.req[1];
    end
    if (reset) begin
      grant_vld = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    if (grant_vld) begin
      last_d = grant_id;
      if (bus.lock[grant_id]) begin
        state_d     = OWN;
        owner_d     = grant_id;
        burst_cnt_d = extend ? burst_cnt_q + CW'(1) : CW'(1);
      end else begin
        state_d     = IDLE;
        burst_cnt_d = '0;
      end
    end
    tag_vld_d[0] = grant_vld && !bus.we[grant_id];
    tag_id_d[0]  = grant_id;
    for (int i = 1; i < READ_LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      burst_cnt_q <= '0;
      tag_vld_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      tag_vld_q   <= tag_vld_d;
    end
  end

  // NOTE: tag ids are qualified by tag_vld_q, so this datapath storage needs no reset.
  always_ff @(posedge clk) begin
    tag_id_q <= tag_id_d;
  end

  always_comb begin
    bus.gnt    = 2'b00;
    bus.rvalid = 2'b00;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_data   = '0;
    if (grant_vld) begin
      bus.gnt[grant_id] = 1'b1;
      ram_we   = bus.we[grant_id];
      ram_addr = grant_id ? bus.addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : bus.addr[ADDR_WIDTH-1:0];
      ram_data = grant_id ? bus.wdata[2*DATA_WIDTH-1:DATA_WIDTH] : bus.wdata[DATA_WIDTH-1:0];
    end
    // Gating with reset drops a read whose tag reaches the output during reset.
    if (!reset && tag_vld_q[READ_LATENCY-1]) begin
      bus.rvalid[tag_id_q[READ_LATENCY-1]] = 1'b1;
    end
  end

  assign bus.rdata = ram_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench: directed vector table plus randomized traffic, both
// compared against a transaction-level arbiter/RAM model kept in the bench.
module tb_ram_port_arbiter;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int RL = 1;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic reset;
  logic init_ram;
  always #5 clk = ~clk;

  ram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          ram_we;
  logic [DW-1:0] ram_q;

  ram_port_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(RL), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .ram_q(ram_q)
  );

  function automatic logic [DW-1:0] init_word(int i);
    logic [31:0] t;
    t = i * 37 + 32'h1000;
    return t[DW-1:0];
  endfunction

  // Synchronous single-port RAM with one cycle of read latency.
  logic [DW-1:0] ram_mem [2**AW];
  always @(posedge clk) begin
    if (init_ram) begin
      for (int i = 0; i < 2**AW; i++) ram_mem[i] <= init_word(i);
    end else begin
      if (ram_we) ram_mem[ram_addr] <= ram_data;
      ram_q <= ram_mem[ram_addr];
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    bit            v;
    bit            id;
    logic [DW-1:0] data;
  } rd_t;

  int            m_owner;
  int            m_cnt;
  int            m_last;
  logic [DW-1:0] shadow [2**AW];
  rd_t           rdq [$];

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] last_gnt;
  logic [1:0] last_rv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_pick(logic [1:0] req);
    if (m_owner >= 0 && req[m_owner]) begin
      if (m_cnt < MB) return m_owner;
      return req[1-m_owner] ? 1 - m_owner : m_owner;
    end
    if (req == 2'b11) return 1 - m_last;
    if (req[0]) return 0;
    if (req[1]) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    rd_t empty;
    empty = '{v: 1'b0, id: 1'b0, data: '0};
    m_owner = -1;
    m_cnt   = 0;
    m_last  = 1;
    rdq.delete();
    for (int i = 0; i < RL; i++) rdq.push_back(empty);
  endtask

  task automatic run_cycle(input logic rst, input logic [1:0] req, input logic [1:0] lock,
                           input logic [1:0] we, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    int            w;
    rd_t           head;
    rd_t           nxt;
    logic [1:0]    exp_gnt;
    logic [1:0]    exp_rv;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic          exp_we;

    reset      = rst;
    bus.req    = req;
    bus.lock   = lock;
    bus.we     = we;
    bus.addr   = {a1, a0};
    bus.wdata  = {d1, d0};

    w        = rst ? -1 : model_pick(req);
    head     = rdq[0];
    exp_gnt  = (w < 0) ? 2'b00 : ((w == 1) ? 2'b10 : 2'b01);
    exp_rv   = (!rst && head.v) ? (head.id ? 2'b10 : 2'b01) : 2'b00;
    exp_we   = (w >= 0) && we[w];
    exp_addr = (w < 0) ? '0 : ((w == 1) ? a1 : a0);
    exp_data = (w < 0) ? '0 : ((w == 1) ? d1 : d0);

    @(negedge clk);
    check("gnt",      32'(bus.gnt),    32'(exp_gnt));
    check("ram_we",   32'(ram_we),     32'(exp_we));
    check("ram_addr", 32'(ram_addr),   32'(exp_addr));
    check("ram_data", 32'(ram_data),   32'(exp_data));
    check("rvalid",   32'(bus.rvalid), 32'(exp_rv));
    if (exp_rv != 2'b00) check("rdata", 32'(bus.rdata), 32'(head.data));
    last_gnt = bus.gnt;
    last_rv  = bus.rvalid;

    void'(rdq.pop_front());
    if (rst) begin
      model_reset();
    end else begin
      nxt = '{v: 1'b0, id: 1'b0, data: '0};
      if (w >= 0) begin
        if (we[w]) begin
          shadow[exp_addr] = exp_data;
        end else begin
          nxt = '{v: 1'b1, id: w[0], data: shadow[exp_addr]};
        end
        if (lock[w]) begin
          m_cnt   = (m_owner == w && m_cnt < MB) ? m_cnt + 1 : 1;
          m_owner = w;
        end else begin
          m_owner = -1;
          m_cnt   = 0;
        end
        m_last = w;
      end
      rdq.push_back(nxt);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic          rst;
    logic [1:0]    req;
    logic [1:0]    lock;
    logic [1:0]    we;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic [1:0]    eg;
    logic [1:0]    erv;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(logic rst, logic [1:0] req, logic [1:0] lock, logic [1:0] we,
                              logic [AW-1:0] a0, logic [AW-1:0] a1, logic [DW-1:0] d0,
                              logic [1:0] eg, logic [1:0] erv);
    vec_t v;
    v = '{rst: rst, req: req, lock: lock, we: we, a0: a0, a1: a1,
          d0: d0, d1: 16'h0, eg: eg, erv: erv};
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 2**AW; i++) shadow[i] = init_word(i);
    model_reset();
    init_ram  = 1'b1;
    reset     = 1'b1;
    bus.req   = 2'b00;
    bus.lock  = 2'b00;
    bus.we    = 2'b00;
    bus.addr  = '0;
    bus.wdata = '0;
    @(posedge clk);
    #1;
    init_ram = 1'b0;

    // reset
    vecs.push_back(mk(1, 2'b11, 2'b00, 2'b00, 10'h005, 10'h200, 16'h0, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 16'h0, 2'b00, 2'b00));
    // alternating reads, both requesting
    vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, 10'h005, 10'h200, 16'h0, 2'b01, 2'b00));
    vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, 10'h005, 10'h200, 16'h0, 2'b10, 2'b01));
    vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, 10'h005, 10'h200, 16'h0, 2'b01, 2'b10));
    vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, 10'h005, 10'h200, 16'h0, 2'b10, 2'b01));
    // write then read-after-write
    vecs.push_back(mk(0, 2'b01, 2'b00, 2'b01, 10'h010, 10'h000, 16'hBEEF, 2'b01, 2'b10));
    vecs.push_back(mk(0, 2'b01, 2'b00, 2'b00, 10'h010, 10'h000, 16'h0, 2'b01, 2'b00));
    vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 16'h0, 2'b00, 2'b01));
    // r1 locked burst against continuous r0
    vecs.push_back(mk(0, 2'b11, 2'b10, 2'b00, 10'h020, 10'h300, 16'h0, 2'b10, 2'b00));
    vecs.push_back(mk(0, 2'b11, 2'b10, 2'b00, 10'h020, 10'h300, 16'h0, 2'b10, 2'b10));
    vecs.push_back(mk(0, 2'b11, 2'b10, 2'b00, 10'h020, 10'h300, 16'h0, 2'b10, 2'b10));
    vecs.push_back(mk(0, 2'b11, 2'b10, 2'b00, 10'h020, 10'h300, 16'h0, 2'b10, 2'b10));
    vecs.push_back(mk(0, 2'b11, 2'b10, 2'b00, 10'h020, 10'h300, 16'h0, 2'b01, 2'b10));
    vecs.push_back(mk(0, 2'b11, 2'b10, 2'b00, 10'h020, 10'h300, 16'h0, 2'b10, 2'b01));
    // r0 alone with lock: forced release re-grants with no gap
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(0, 2'b01, 2'b01, 2'b00, 10'h030, 10'h000, 16'h0, 2'b01,
                        (i == 0) ? 2'b10 : 2'b01));
    // read by r1, then reset drops it
    vecs.push_back(mk(0, 2'b10, 2'b00, 2'b00, 10'h000, 10'h3FF, 16'h0, 2'b10, 2'b01));
    vecs.push_back(mk(1, 2'b11, 2'b00, 2'b00, 10'h005, 10'h200, 16'h0, 2'b00, 2'b00));
    vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, 10'h005, 10'h200, 16'h0, 2'b01, 2'b00));
    vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, 10'h005, 10'h200, 16'h0, 2'b10, 2'b01));
    // idle
    vecs.push_back(mk(0, 2'b00, 2'b11, 2'b11, 10'h055, 10'h2AA, 16'h1234, 2'b00, 2'b10));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 10'h055, 10'h2AA, 16'h1234, 2'b00, 2'b00));

    foreach (vecs[i]) begin
      run_cycle(vecs[i].rst, vecs[i].req, vecs[i].lock, vecs[i].we,
                vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
      check($sformatf("vec%0d_gnt", i),    32'(last_gnt), 32'(vecs[i].eg));
      check($sformatf("vec%0d_rvalid", i), 32'(last_rv),  32'(vecs[i].erv));
    end

    // randomized traffic against the model, with occasional resets
    for (int n = 0; n < 600; n++) begin
      logic          r_rst;
      logic [1:0]    r_req;
      logic [1:0]    r_lock;
      logic [1:0]    r_we;
      logic [AW-1:0] r_a0;
      logic [AW-1:0] r_a1;
      r_rst  = ($urandom_range(0, 49) == 0);
      r_req  = ($urandom_range(0, 2) == 0) ? 2'(3) : 2'($urandom_range(0, 3));
      r_lock = 2'($urandom_range(0, 3));
      r_we   = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      r_a0   = AW'($urandom_range(0, 15));
      r_a1   = AW'($urandom_range(0, 15));
      run_cycle(r_rst, r_req, r_lock, r_we, r_a0, r_a1, DW'($urandom), DW'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Shares one port of the dual-port data RAM between two requesters (requester 0 = CPU load/store unit, requester 1 = VGA/peripheral fetch engine). It grants at most one access per cycle with round-robin fairness and optional bounded burst locking. It routes read data back with a per-requester valid strobe aligned to the RAM's synchronous read latency. It sits directly between the requesters and the RAM `addr/data/we/q` port pins.

## Interface
- DATA_WIDTH, 16, RAM word width
- ADDR_WIDTH, 10, RAM word-address width
- READ_LATENCY, 1, clocks from RAM address capture to valid `ram_q` (≥1)
- MAX_BURST, 4, max consecutive grants to one locked requester (≥1)

- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- req  in  2  bit i: requester i wants an access this cycle
- lock  in  2  bit i: requester i asks to keep ownership after this grant
- we  in  2  bit i: access is a write (1) or read (0)
- addr  in  2*ADDR_WIDTH  requester 0 in [ADDR_WIDTH-1:0], requester 1 in upper half
- wdata  in  2*DATA_WIDTH  same packing as addr
- gnt  out  2  one-hot or zero; access of requester i is performed this cycle
- rvalid  out  2  bit i: `rdata` holds the result of requester i's read
- rdata  out  DATA_WIDTH  shared read-return bus, equals `ram_q`
- ram_addr  out  ADDR_WIDTH  to RAM port address
- ram_data  out  DATA_WIDTH  to RAM port write data
- ram_we  out  1  to RAM port write enable
- ram_q  in  DATA_WIDTH  from RAM port read data

## Operation
- Registered state: `state` ∈ {IDLE, OWN}, `owner` (1 bit), `last` (last-granted id), `burst_cnt` (counts to MAX_BURST), tag pipeline of READ_LATENCY stages of {valid, id}.
- Arbitration each cycle; `gnt` is combinational from `req`, `lock` and registered state:
  - IDLE, or OWN whose owner dropped `req`: a single requester wins. If both request, the one ≠ `last` wins.
  - OWN with `req[owner]=1`: owner wins if `burst_cnt < MAX_BURST`. Otherwise a forced release occurs: the other requester wins if it requests, else the owner is re-granted and `burst_cnt` restarts at 1.
- On grant to i: `last←i`. If `lock[i]=1`, then `state←OWN`, `owner←i` and `burst_cnt` increments (1 on the first grant). If `lock[i]=0`, then `state←IDLE` and `burst_cnt←0`.
- The granted requester's addr, wdata and we drive `ram_addr`, `ram_data` and `ram_we`. With no grant, `ram_we=0`, `ram_addr=0` and `ram_data=0`.
- A granted read pushes {1, i} into the tag pipeline. Writes and idle cycles push {0, x}. At the pipeline output, valid with id i sets `rvalid[i]=1`.
- `rdata = ram_q` at all times. Requesters sample it only while their `rvalid` is high.
- Reset values: `state=IDLE`, `last=1` (requester 0 wins the first tie), `burst_cnt=0`, all tag stages invalid. `gnt` is forced to 0 and `ram_we=0` while `reset=1`, and `rvalid=0`.
- Reset mid-burst or with reads in flight: ownership is dropped, and in-flight reads are discarded (their `rvalid` never fires).

## Timing
- Grant latency is 0: a request presented in cycle n with no contention gets `gnt` in cycle n.
- A write commits at the clk edge ending the grant cycle.
- Read data: `rvalid[i]` is high exactly READ_LATENCY cycles after the grant cycle, for 1 cycle per read.
- Throughput is one access per cycle. Back-to-back reads by both requesters return in grant order.
- Write at cycle n then read of the same address at n+1 returns the new data.
- If both `req` rise in the same cycle from IDLE after reset, requester 0 is granted first and requester 1 next cycle.
- Starvation bound: a continuously requesting requester is granted within MAX_BURST+1 cycles.
- No combinational path from `ram_q` to `gnt`, `ram_*`, or any state.

## Test plan
- Reset, then `req=2'b11`, lock=0, reads to addr 0x005 (r0) and 0x200 (r1) held 4 cycles. Required: `gnt` = 01,10,01,10. `rvalid` = 01,10,01,10 delayed by 1 cycle, with `rdata` matching the preloaded words.
- r0 writes 0xBEEF to 0x010 in cycle n, then reads 0x010 in n+1. Required: `rvalid[0]` in n+2 with `rdata=0xBEEF`, and `ram_we=1` only in cycle n.
- r1 holds lock=1 and req=1 while r0 requests continuously, MAX_BURST=4. Required: `gnt`=10 for 4 cycles, then 01 for 1 cycle, then r1 regains.
- Only r0 requests, lock=1, for 6 cycles. Required: `gnt`=01 every cycle, with `burst_cnt` restarting after 4 and no idle gap.
- Issue a granted read by r1, then assert `reset` in the next cycle. Required: `rvalid` stays 00, `gnt`=00 and `ram_we=0` during reset. After release with `req=2'b11`, r0 is granted first.
- No requests for 3 cycles. Required: `gnt`=00, `ram_we=0`, `ram_addr=0`, `rvalid`=00.
